circle_draw_param: RTL

Parametrised midpoint-circle drawing engine, the next generation of the lab's shape drawers. It takes a centre, a diameter and a colour, and emits one pixel-write per cycle toward the VGA adapter. Compared with the fixed-size shape blocks it adds:
- generic screen and coordinate widths;
- a selectable outline or filled mode;
- full clipping of off-screen pixels at any centre, including centres outside the screen;
- deterministic, data-dependent latency, so the bench can predict `done` exactly.

---
 rtl/circle_draw_param.sv | 247 ++++++++++++++++++++++++
 1 files changed

// File: rtl/circle_draw_param.sv
// circle_draw_param: midpoint-circle drawing engine with screen clipping.
//
// Takes a centre, a diameter (radius = diameter >> 1) and a colour. It then emits one
// candidate pixel per cycle toward a VGA adapter, either as an outline (eight octant points
// per iteration) or as a filled disc (four horizontal spans per iteration). Candidates that
// fall off-screen still take their cycle, but their strobe stays low.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   start / done       level request / completion (done held while start stays high)
//   centre_x/centre_y  circle centre, unsigned, may lie off-screen
//   diameter           circle diameter, LSB ignored
//   colour, fill       pixel colour; 0 = outline, 1 = filled disc
//   vga_x/vga_y        pixel coordinate (0 when vga_plot=0)
//   vga_colour         pixel colour (0 when vga_plot=0)
//   vga_plot           pixel-write strobe
module circle_draw_param #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter int unsigned X_W      = 8,
    parameter int unsigned Y_W      = 7,
    parameter int unsigned D_W      = 8,
    parameter int unsigned COLOUR_W = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                done,
    input  logic [X_W-1:0]      centre_x,
    input  logic [Y_W-1:0]      centre_y,
    input  logic [D_W-1:0]      diameter,
    input  logic [COLOUR_W-1:0] colour,
    input  logic                fill,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [COLOUR_W-1:0] vga_colour,
    output logic                vga_plot
);

    // Coordinate width leaves room for centre +/- radius without wrap-around.
    localparam int unsigned XY_W   = (X_W > Y_W) ? X_W : Y_W;
    localparam int unsigned C_W    = ((XY_W > D_W) ? XY_W : D_W) + 2;
    localparam int unsigned CRIT_W = D_W + 3;

    localparam logic signed [C_W-1:0]    ONE      = C_W'(1);
    localparam logic signed [C_W-1:0]    ZERO     = '0;
    localparam logic signed [C_W-1:0]    SCR_W    = C_W'(SCREEN_W);
    localparam logic signed [C_W-1:0]    SCR_H    = C_W'(SCREEN_H);
    localparam logic signed [CRIT_W-1:0] CRIT_ONE = CRIT_W'(1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StPlot,
        StSpan,
        StUpdate,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic signed [C_W-1:0]    cx_q, cx_d;
    logic signed [C_W-1:0]    cy_q, cy_d;
    logic [D_W-1:0]           radius_q, radius_d;
    logic [COLOUR_W-1:0]      colour_q, colour_d;
    logic                     fill_q, fill_d;
    logic signed [C_W-1:0]    ox_q, ox_d;
    logic signed [C_W-1:0]    oy_q, oy_d;
    logic signed [CRIT_W-1:0] crit_q, crit_d;
    logic [2:0]               k_q, k_d;
    logic [1:0]               span_q, span_d;
    // Span x position as an offset from cx, running -half..+half.
    logic signed [C_W-1:0]    off_q, off_d;

    logic signed [C_W-1:0]    oy_n, ox_n, delta, half, next_half;
    logic signed [CRIT_W-1:0] delta_c;
    logic signed [C_W-1:0]    cand_x, cand_y;
    logic                     visible;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            cx_q     <= '0;
            cy_q     <= '0;
            radius_q <= '0;
            colour_q <= '0;
            fill_q   <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            k_q      <= '0;
            span_q   <= '0;
            off_q    <= '0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            radius_q <= radius_d;
            colour_q <= colour_d;
            fill_q   <= fill_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            crit_q   <= crit_d;
            k_q      <= k_d;
            span_q   <= span_d;
            off_q    <= off_d;
        end
    end

    // Spans 0/1 run across +/-ox, spans 2/3 across +/-oy.
    assign half      = span_q[1] ? oy_q : ox_q;
    assign next_half = (span_q == 2'd0) ? ox_q : oy_q;

    // Next-state and iteration datapath
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        radius_d = radius_q;
        colour_d = colour_q;
        fill_d   = fill_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        k_d      = k_q;
        span_d   = span_q;
        off_d    = off_q;

        // Midpoint step, both branches use the already-updated oy (and ox).
        oy_n = oy_q + ONE;
        ox_n = ox_q;
        if (crit_q[CRIT_W-1] || (crit_q == '0)) begin
            delta = (oy_n <<< 1) + ONE;
        end else begin
            ox_n  = ox_q - ONE;
            delta = ((oy_n - ox_n) <<< 1) + ONE;
        end
        delta_c = CRIT_W'(delta);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    cx_d     = $signed(C_W'(centre_x));
                    cy_d     = $signed(C_W'(centre_y));
                    radius_d = diameter >> 1;
                    colour_d = colour;
                    fill_d   = fill;
                    state_d  = StInit;
                end
            end
            StInit: begin
                ox_d    = $signed(C_W'(radius_q));
                oy_d    = ZERO;
                crit_d  = CRIT_ONE - $signed(CRIT_W'(radius_q));
                k_d     = '0;
                span_d  = '0;
                off_d   = ZERO - $signed(C_W'(radius_q));
                state_d = fill_q ? StSpan : StPlot;
            end
            StPlot: begin
                k_d = k_q + 3'd1;
                if (k_q == 3'd7) begin
                    state_d = StUpdate;
                end
            end
            StSpan: begin
                if (off_q == half) begin
                    if (span_q == 2'd3) begin
                        state_d = StUpdate;
                    end else begin
                        span_d = span_q + 2'd1;
                        off_d  = ZERO - next_half;
                    end
                end else begin
                    off_d = off_q + ONE;
                end
            end
            StUpdate: begin
                oy_d   = oy_n;
                ox_d   = ox_n;
                crit_d = crit_q + delta_c;
                k_d    = '0;
                span_d = '0;
                off_d  = ZERO - ox_n;
                if (oy_n <= ox_n) begin
                    state_d = fill_q ? StSpan : StPlot;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (!start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Candidate pixel for the current PLOT octant or SPAN position
    always_comb begin
        cand_x = ZERO;
        cand_y = ZERO;
        if (state_q == StSpan) begin
            cand_x = cx_q + off_q;
            unique case (span_q)
                2'd0: cand_y = cy_q + oy_q;
                2'd1: cand_y = cy_q - oy_q;
                2'd2: cand_y = cy_q + ox_q;
                2'd3: cand_y = cy_q - ox_q;
                default: cand_y = ZERO;
            endcase
        end else begin
            unique case (k_q)
                3'd0: begin cand_x = cx_q + ox_q; cand_y = cy_q + oy_q; end
                3'd1: begin cand_x = cx_q + oy_q; cand_y = cy_q + ox_q; end
                3'd2: begin cand_x = cx_q - ox_q; cand_y = cy_q + oy_q; end
                3'd3: begin cand_x = cx_q - oy_q; cand_y = cy_q + ox_q; end
                3'd4: begin cand_x = cx_q - ox_q; cand_y = cy_q - oy_q; end
                3'd5: begin cand_x = cx_q - oy_q; cand_y = cy_q - ox_q; end
                3'd6: begin cand_x = cx_q + ox_q; cand_y = cy_q - oy_q; end
                3'd7: begin cand_x = cx_q + oy_q; cand_y = cy_q - ox_q; end
                default: begin cand_x = ZERO; cand_y = ZERO; end
            endcase
        end
    end

    assign visible = !cand_x[C_W-1] && (cand_x < SCR_W) &&
                     !cand_y[C_W-1] && (cand_y < SCR_H);

    // Outputs
    always_comb begin
        done       = (state_q == StDone);
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        if (((state_q == StPlot) || (state_q == StSpan)) && visible) begin
            vga_plot   = 1'b1;
            vga_x      = cand_x[X_W-1:0];
            vga_y      = cand_y[Y_W-1:0];
            vga_colour = colour_q;
        end
    end

endmodule
